ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the open-drain inhibit/request-to-send sequence, then checks the device ACK. It sits beside the keyboard receive path in the top-level shell and shares the ps2_clk/ps2_data lines through open-drain enables. busy is used to gate the receiver during a host transmission.

Parameters:
INHIBIT_CYC, 12000, cycles ps2 clock is held low before request-to-send (120 us at 100 MHz).
TIMEOUT_CYC, 2000000, watchdog cycles allowed between device clock falling edges, including the first (20 ms).
SYNC_STAGES, 2, flip-flop depth of the input synchronisers.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
tx_data  in  8  command byte, sampled when tx_valid && tx_ready
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high only in IDLE
ps2_clk_in  in  1  raw ps2 clock line level
ps2_data_in  in  1  raw ps2 data line level
ps2_clk_oe  out  1  1 = pull ps2 clock low; 0 = release
ps2_data_oe  out  1  1 = pull ps2 data low; 0 = release
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: frame sent and ACK received
ack_err  out  1  one-cycle pulse: device did not ACK
timeout  out  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset (async) values: state IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done/ack_err/timeout=0; counters cleared. Reset mid-frame releases both lines immediately, with no glitch to low.
- Inputs pass through a SYNC_STAGES synchroniser. fall = synced clk was 1 last cycle and is 0 now.
- The shift register holds {stop=1, parity, data[7:0]}. parity = ~^tx_data (odd parity). It is latched on accept.
- IDLE: on tx_valid, latch the byte, clear the counter, and go to INHIBIT. tx_valid while busy is ignored.
- INHIBIT: clk_oe=1 for INHIBIT_CYC cycles. During the last cycle data_oe is set to 1 (start bit). Then go to RTS.
- RTS: clk_oe=0, data_oe stays 1. Wait for fall, then go to BITS with bit_cnt=0.
- BITS: on each fall, data_oe <= ~shift[0], shift right, bit_cnt++. The update is registered, so data_oe changes one cycle after fall is detected.
  - Falls 1–8 drive data bits LSB first.
  - Fall 9 drives parity.
  - Fall 10 drives the stop bit (data_oe=0, released). Then go to ACK.
- ACK: on the next fall (11th overall), sample synced data.
  - If data is 0, go to WAIT_IDLE with ack_ok=1.
  - If data is 1, go to WAIT_IDLE with ack_ok=0.
- WAIT_IDLE: both oe=0. When synced clk=1 and data=1 for one cycle, pulse done (if ack_ok) or ack_err (if not), then return to IDLE.
- Watchdog: active in RTS, BITS, ACK and WAIT_IDLE. It counts cycles since entry or since the last fall and resets on each fall. On reaching TIMEOUT_CYC: release both lines, pulse timeout, go to IDLE. Nothing else is signalled.
- Simultaneous watchdog expiry and fall: the fall wins and the counter clears.
- done, ack_err and timeout are mutually exclusive, with exactly one pulse per accepted byte.
- Counter widths are $clog2 of the larger of INHIBIT_CYC and TIMEOUT_CYC, plus 1. bit_cnt is 4 bits.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE);
  - command constants CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - timing defaults.
- One sub-module, ps2_line_sync: a SYNC_STAGES synchroniser for clk and data plus the falling-edge detect. The receiver can reuse it.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - clk_oe is low for 12000 cycles.
  - Data bits are 1,0,1,1,0,1,1,1, then parity 1, then stop released.
  - done pulses once; ack_err=0 and timeout=0.
- Send 0x01 and 0x00: observed parity bits are 0 and 1 respectively. Send 0xFF: parity 1.
- The device model releases data at the 11th edge, with no ACK: ack_err pulses once, done=0, and the bench sees lines released.
- No device clock after RTS: timeout pulses exactly TIMEOUT_CYC cycles after RTS entry, both oe=0, and tx_ready=1 the next cycle.
- Assert rst at fall 5 of a frame: both oe are 0 in the same cycle, with no pulse on any status output. A following 0xF4 then completes with done.
- Hold tx_valid with a different byte through a whole frame: only the first byte is sent. The second byte is accepted only after tx_ready returns to 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host path: state encodings, keyboard
// command bytes, timing defaults and small helpers.
package ps2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INHIBIT   = 3'd1;
  localparam state_t ST_RTS       = 3'd2;
  localparam state_t ST_BITS      = 3'd3;
  localparam state_t ST_ACK       = 3'd4;
  localparam state_t ST_WAIT_IDLE = 3'd5;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // 100 MHz system clock: 120 us inhibit, 20 ms per-edge watchdog.
  localparam int DEF_INHIBIT_CYC = 12000;
  localparam int DEF_TIMEOUT_CYC = 2000000;
  localparam int DEF_SYNC_STAGES = 2;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // One counter serves both the inhibit delay and the watchdog.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS/2 clock and data lines into the system clock
// domain and flags falling edges of the device clock. Shared with the
// receive path.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic line_clk,
  input  logic line_data,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  // Synchroniser chains plus one history bit for edge detection. Idle bus
  // level is high, so resetting to 1 avoids a phantom fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], line_clk};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], line_data};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sr[SYNC_STAGES-1];
  assign data_s = data_sr[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out one command byte on device clock falls, then checks the ACK.
// Drives the shared lines only through open-drain enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int CNT_W = cnt_width(INHIBIT_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] INH_START = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       shift;    // {stop, parity, data[7:0]}, LSB goes first
  logic [3:0]       bit_cnt;
  logic             ack_ok;
  logic             clk_s;
  logic             data_s;
  logic             fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .line_clk  (ps2_clk_in),
    .line_data (ps2_data_in),
    .clk_s     (clk_s),
    .data_s    (data_s),
    .fall      (fall)
  );

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Frame sequencer: state, shared inhibit/watchdog counter, shifter,
  // registered open-drain enables and single-cycle status pulses.
  // NOTE: all state here uses non-blocking assignment so every branch sees
  // the pre-edge values; blocking would make the result order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      ack_ok      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      // NOTE: status outputs default low each cycle so any set below is a
      // one-cycle pulse.
      done    <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            shift      <= {1'b1, odd_parity(tx_data), tx_data};
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          cnt <= cnt + 1'b1;
          // Start bit goes down one cycle before the clock is released.
          if (cnt == INH_START) ps2_data_oe <= 1'b1;
          if (cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= ST_RTS;
          end
        end

        ST_RTS, ST_BITS, ST_ACK, ST_WAIT_IDLE: begin
          // A fall always beats watchdog expiry and restarts the count.
          if (fall) begin
            cnt <= '0;
            case (state)
              ST_RTS: begin
                // This fall clocks the start bit into the device.
                bit_cnt <= '0;
                state   <= ST_BITS;
              end
              ST_BITS: begin
                ps2_data_oe <= ~shift[0];
                shift       <= shift >> 1;
                bit_cnt     <= bit_cnt + 1'b1;
                if (bit_cnt == 4'd9) state <= ST_ACK;
              end
              ST_ACK: begin
                ack_ok <= ~data_s;
                state  <= ST_WAIT_IDLE;
              end
              default: ;
            endcase
          end else if (state == ST_WAIT_IDLE && clk_s && data_s) begin
            done    <= ack_ok;
            ack_err <= ~ack_ok;
            state   <= ST_IDLE;
          end else if (cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout     <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a behavioural
// keyboard that clocks frames, samples bits on rising edges and ACKs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 200;
  localparam int TIMEOUT = 1500;
  localparam int HALF    = 50;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  logic dev_clk  = 1'b1;   // 0 = device pulls clock low
  logic dev_data = 1'b1;   // 0 = device pulls data low

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_ackerr = 0;
  int n_to     = 0;

  assign ps2_clk_in  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign ps2_data_in = ps2_data_oe ? 1'b0 : dev_data;

  ps2_host_tx #(
    .INHIBIT_CYC (INHIBIT),
    .TIMEOUT_CYC (TIMEOUT),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)    n_done++;
    if (ack_err) n_ackerr++;
    if (timeout) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit hold);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Counts negedges with the clock inhibited; returns at the first released
  // sample, which is the first cycle of request-to-send.
  task automatic inhibit_len(output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) n++;
      else if (n > 0) break;
    end
  endtask

  // Keyboard: start-bit clock, ten clocks for data/parity/stop sampled on
  // the rising edge, then the ACK clock. abort_at stops after that fall.
  task automatic device(input bit ack, input int abort_at, output logic [9:0] got);
    got = '0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    for (int k = 0; k < 10; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (k + 1 == abort_at) return;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      got[k] = ps2_data_in;
    end
    repeat (HALF - 10) @(negedge clk);
    if (ack) dev_data = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic wait_pulse(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || ack_err || timeout) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input bit ack,
                       input logic [9:0] exp_got);
    int         d0, a0, t0, n;
    logic [9:0] got;
    bit         seen;
    d0 = n_done; a0 = n_ackerr; t0 = n_to;
    send(b, 1'b0);
    check({tag, " busy/ready"}, {30'd0, busy, tx_ready}, 32'd2);
    inhibit_len(n);
    check({tag, " inhibit cycles"}, n, INHIBIT);
    check({tag, " start bit"}, {31'd0, ps2_data_oe}, 32'd1);
    device(ack, 0, got);
    check({tag, " line bits"}, {22'd0, got}, {22'd0, exp_got});
    wait_pulse(seen);
    check({tag, " status seen"}, {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    check({tag, " done count"}, n_done - d0, ack ? 1 : 0);
    check({tag, " ack_err count"}, n_ackerr - a0, ack ? 0 : 1);
    check({tag, " timeout count"}, n_to - t0, 0);
    check({tag, " lines released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check({tag, " ready"}, {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int         d0, a0, t0, n;
    logic [9:0] got;
    bit         seen;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst ready/busy", {30'd0, tx_ready, busy}, 32'd2);
    check("rst pulses", {29'd0, done, ack_err, timeout}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Normal frames; expected line bits are {stop, parity, data}.
    frame("ED", CMD_SET_LED, 1'b1, 10'h3ED);
    frame("01", 8'h01, 1'b1, 10'h201);
    frame("00", 8'h00, 1'b1, 10'h300);
    frame("FF", CMD_RESET, 1'b1, 10'h3FF);

    // Device releases data at the ACK clock: no acknowledge.
    frame("nack", CMD_SET_LED, 1'b0, 10'h3ED);

    // No device clock after request-to-send.
    d0 = n_done; a0 = n_ackerr; t0 = n_to;
    send(CMD_RESET, 1'b0);
    inhibit_len(n);
    check("to inhibit", n, INHIBIT);
    n = 0;
    for (int i = 1; i <= 2 * TIMEOUT; i++) begin
      @(negedge clk);
      if (timeout) begin
        n = i;
        break;
      end
    end
    check("to latency", n, TIMEOUT);
    check("to oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge clk);
    check("to ready next", {31'd0, tx_ready}, 32'd1);
    repeat (2) @(negedge clk);
    check("to pulses", {n_done - d0, n_ackerr - a0, n_to - t0}, {32'd0, 32'd0, 32'd1});

    // Reset at fall 5, while bit 4 of 0xED (a 0) is being driven.
    d0 = n_done; a0 = n_ackerr; t0 = n_to;
    send(CMD_SET_LED, 1'b0);
    inhibit_len(n);
    device(1'b1, 5, got);
    repeat (8) @(negedge clk);
    check("mid data_oe", {31'd0, ps2_data_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid rst oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("mid rst busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    dev_clk = 1'b1;
    rst     = 1'b0;
    repeat (4) @(negedge clk);
    check("mid rst pulses", n_done - d0 + n_ackerr - a0 + n_to - t0, 0);
    frame("F4", CMD_ENABLE, 1'b1, 10'h2F4);

    // tx_valid held with a changed byte across a whole frame.
    d0 = n_done;
    send(8'h12, 1'b1);
    @(negedge clk);
    tx_data = 8'h5A;
    check("hold ready low", {31'd0, tx_ready}, 32'd0);
    inhibit_len(n);
    device(1'b1, 0, got);
    check("hold first byte", {22'd0, got}, 32'h312);
    wait_pulse(seen);
    check("hold done ready", {30'd0, done, tx_ready}, 32'd3);
    inhibit_len(n);
    tx_valid = 1'b0;
    check("hold second inhibit", n, INHIBIT);
    device(1'b1, 0, got);
    check("hold second byte", {22'd0, got}, 32'h35A);
    wait_pulse(seen);
    repeat (4) @(negedge clk);
    check("hold done count", n_done - d0, 2);
    check("hold idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
